// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
//   N-digit BCD up/down counter driven by a built-in tick prescaler, with one
//   registered seven-segment encoder per digit.
//
// Parameters
//   DIGITS          number of BCD digits (1..8)
//   TICK_DIV        enabled clock cycles per count step (>= 1)
//   SEG_ACTIVE_LOW  1: lit segment driven 0, 0: lit segment driven 1
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   en         prescaler run enable
//   up         count direction (1 = up, 0 = down), sampled on step edges
//   clr        synchronous clear (highest priority)
//   load       synchronous load of load_val (digits > 9 saturate to 9)
//   load_val   BCD load value, digit 0 in bits [3:0]
//   count_bcd  registered BCD count
//   tick_o     one-cycle pulse, coincident with the count after a step
//   wrap_o     one-cycle pulse, coincident with the count after a wrap step
//   seg        segment bytes {dp,g,f,e,d,c,b,a}, digit i in [8i+7:8i],
//              one cycle behind count_bcd
module bcd_tick_counter #(
  parameter int DIGITS         = 2,
  parameter int TICK_DIV       = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  tick_o,
  output logic                  wrap_o,
  output logic [8*DIGITS-1:0]   seg
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [4*DIGITS-1:0] sat_bcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = sat_digit(v[4*i +: 4]);
    return r;
  endfunction

  // Returns {wrap, next_count}. The carry/borrow ripples through every digit
  // combinationally; a carry out of the top digit is the wrap.
  function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                  input logic              dir_up);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    logic [3:0]          d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (dir_up) begin
          if (d >= 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return {carry, r};
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'h3F;
      4'd1:    p = 8'h06;
      4'd2:    p = 8'h5B;
      4'd3:    p = 8'h4F;
      4'd4:    p = 8'h66;
      4'd5:    p = 8'h6D;
      4'd6:    p = 8'h7D;
      4'd7:    p = 8'h07;
      4'd8:    p = 8'h7F;
      4'd9:    p = 8'h6F;
      default: p = 8'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  logic [PW-1:0]         presc_p0;
  logic [4*DIGITS-1:0]   count_p0;
  logic                  vld_p0;
  logic                  wrap_p0;
  logic [8*DIGITS-1:0]   seg_p1;

  logic                  step;
  logic [4*DIGITS:0]     step_res;
  logic [8*DIGITS-1:0]   seg_next;

  assign step     = en && !clr && !load && (presc_p0 == PRESC_LAST);
  assign step_res = bcd_step(count_p0, up);

  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) seg_next[8*i +: 8] = seg_encode(count_p0[4*i +: 4]);
  end

  // ---- stage p0: prescaler, count, tick/wrap pulses ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_p0 <= '0;
      count_p0 <= '0;
      vld_p0   <= 1'b0;
      wrap_p0  <= 1'b0;
    end else begin
      vld_p0  <= step;
      wrap_p0 <= step & step_res[4*DIGITS];
      if (clr) begin
        presc_p0 <= '0;
        count_p0 <= '0;
      end else if (load) begin
        presc_p0 <= '0;
        count_p0 <= sat_bcd(load_val);
      end else if (en) begin
        if (presc_p0 == PRESC_LAST) begin
          presc_p0 <= '0;
          count_p0 <= step_res[4*DIGITS-1:0];
        end else begin
          presc_p0 <= presc_p0 + PW'(1);
        end
      end
    end
  end

  // ---- stage p1: segment encoding of the p0 count ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) seg_p1 <= {DIGITS{SEG_OFF}};
    else         seg_p1 <= seg_next;
  end

  assign count_bcd = count_p0;
  assign tick_o    = vld_p0;
  assign wrap_o    = wrap_p0;
  assign seg       = seg_p1;

endmodule

// File: tb/tb_bcd_tick_counter.sv
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        resetn, en, up, clr, load;
  logic [7:0]  load_val;
  logic [7:0]  count_bcd, count1;
  logic        tick_o, wrap_o, tick1, wrap1;
  logic [15:0] seg, seg1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] lo [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] hi [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  bcd_tick_counter #(.DIGITS(2), .TICK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count_bcd(count_bcd), .tick_o(tick_o), .wrap_o(wrap_o), .seg(seg));

  bcd_tick_counter #(.DIGITS(2), .TICK_DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count_bcd(count1), .tick_o(tick1), .wrap_o(wrap1), .seg(seg1));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    #12;
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", count_bcd); end
    checks++; if (tick_o !== 1'b0 || wrap_o !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", tick_o, wrap_o); end
    checks++; if (seg !== 16'hFFFF) begin failures++; $display("FAIL reset_seg got=%h exp=FFFF", seg); end
    resetn = 1'b1;
    cyc();
    checks++; if (seg !== 16'hC0C0) begin failures++; $display("FAIL reset_first_seg got=%h exp=C0C0", seg); end
  endtask

  task automatic test_free_run();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      checks++; if (count_bcd !== to_bcd2(k / 4)) begin failures++; $display("FAIL free_count k=%0d got=%h exp=%h", k, count_bcd, to_bcd2(k / 4)); end
      checks++; if (tick_o !== (k % 4 == 0)) begin failures++; $display("FAIL free_tick k=%0d got=%b", k, tick_o); end
      checks++; if (seg !== {lo[((k - 1) / 4) / 10], lo[((k - 1) / 4) % 10]}) begin failures++; $display("FAIL free_seg k=%0d got=%h", k, seg); end
    end
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up = 1'b1;
    do_load(8'h99);
    checks++; if (count_bcd !== 8'h99 || tick_o !== 1'b0) begin failures++; $display("FAIL upwrap_load got=%h tick=%b exp=99/0", count_bcd, tick_o); end
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (count_bcd !== 8'h99 || tick_o !== 1'b0) begin failures++; $display("FAIL upwrap_hold got=%h tick=%b exp=99/0", count_bcd, tick_o); end
    cyc();
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL upwrap_count got=%h exp=00", count_bcd); end
    checks++; if (tick_o !== 1'b1 || wrap_o !== 1'b1) begin failures++; $display("FAIL upwrap_flags got=%b%b exp=11", tick_o, wrap_o); end
    cyc();
    checks++; if (tick_o !== 1'b0 || wrap_o !== 1'b0) begin failures++; $display("FAIL upwrap_pulse_end got=%b%b exp=00", tick_o, wrap_o); end
  endtask

  task automatic test_down();
    en = 1'b1; up = 1'b0;
    do_load(8'h10);
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (count_bcd !== 8'h09) begin failures++; $display("FAIL borrow_count got=%h exp=09", count_bcd); end
    checks++; if (tick_o !== 1'b1 || wrap_o !== 1'b0) begin failures++; $display("FAIL borrow_flags got=%b%b exp=10", tick_o, wrap_o); end
    do_load(8'h00);
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (count_bcd !== 8'h99) begin failures++; $display("FAIL downwrap_count got=%h exp=99", count_bcd); end
    checks++; if (tick_o !== 1'b1 || wrap_o !== 1'b1) begin failures++; $display("FAIL downwrap_flags got=%b%b exp=11", tick_o, wrap_o); end
  endtask

  task automatic test_priority();
    en = 1'b1; up = 1'b1;
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc();
    clr = 1'b0; load = 1'b0;
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL clr_over_load got=%h exp=00", count_bcd); end
    do_load(8'hAF);
    checks++; if (count_bcd !== 8'h99) begin failures++; $display("FAIL load_saturate got=%h exp=99", count_bcd); end
    cyc();
    checks++; if (seg !== 16'h9090) begin failures++; $display("FAIL sat_seg got=%h exp=9090", seg); end
    do_load(8'h20);
    cyc(); cyc(); cyc();
    checks++; if (count_bcd !== 8'h20) begin failures++; $display("FAIL pre_step_hold got=%h exp=20", count_bcd); end
    do_load(8'h42);
    checks++; if (count_bcd !== 8'h42 || tick_o !== 1'b0) begin failures++; $display("FAIL load_on_step got=%h tick=%b exp=42/0", count_bcd, tick_o); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (count_bcd !== ((i == 4) ? 8'h43 : 8'h42) || tick_o !== (i == 4)) begin failures++; $display("FAIL restart_period i=%0d got=%h tick=%b", i, count_bcd, tick_o); end
    end
  endtask

  task automatic test_en_gating();
    en = 1'b1; up = 1'b1;
    do_load(8'h00);
    for (int i = 0; i < 32; i++) begin
      en = (i % 2 == 0);
      cyc();
      checks++; if (count_bcd !== to_bcd2((i / 2 + 1) / 4)) begin failures++; $display("FAIL gate_count i=%0d got=%h exp=%h", i, count_bcd, to_bcd2((i / 2 + 1) / 4)); end
      checks++; if (tick_o !== ((i % 2 == 0) && ((i / 2 + 1) % 4 == 0))) begin failures++; $display("FAIL gate_tick i=%0d got=%b", i, tick_o); end
    end
    en = 1'b1;
  endtask

  task automatic test_tick_div1();
    clr = 1'b1;
    cyc();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++; if (count1 !== to_bcd2(i + 1)) begin failures++; $display("FAIL div1_count i=%0d got=%h exp=%h", i, count1, to_bcd2(i + 1)); end
      checks++; if (tick1 !== 1'b1 || wrap1 !== 1'b0) begin failures++; $display("FAIL div1_flags i=%0d got=%b%b exp=10", i, tick1, wrap1); end
      checks++; if (seg1 !== {hi[i / 10], hi[i % 10]}) begin failures++; $display("FAIL div1_seg i=%0d got=%h", i, seg1); end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; up = 1'b1;
    do_load(8'h37);
    cyc();
    checks++; if (count_bcd !== 8'h37 || seg !== 16'hB0F8) begin failures++; $display("FAIL pre_reset got=%h seg=%h exp=37/B0F8", count_bcd, seg); end
    en = 1'b1;
    #3 resetn = 1'b0;
    #1;
    checks++; if (count_bcd !== 8'h00 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin failures++; $display("FAIL async_reset got=%h %b%b exp=00 00", count_bcd, tick_o, wrap_o); end
    checks++; if (seg !== 16'hFFFF) begin failures++; $display("FAIL async_seg got=%h exp=FFFF", seg); end
    cyc(); cyc();
    #3 resetn = 1'b1;
    #1;
    checks++; if (seg !== 16'hFFFF) begin failures++; $display("FAIL release_seg got=%h exp=FFFF", seg); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin
        checks++; if (seg !== 16'hC0C0) begin failures++; $display("FAIL release_first_seg got=%h exp=C0C0", seg); end
      end
      checks++; if (count_bcd !== ((i == 4) ? 8'h01 : 8'h00) || tick_o !== (i == 4)) begin failures++; $display("FAIL release_step i=%0d got=%h tick=%b", i, count_bcd, tick_o); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_up_wrap();
    test_down();
    test_priority();
    test_en_gating();
    test_tick_div1();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised N-digit BCD up/down counter with a built-in tick prescaler and per-digit seven-segment encoders. It is the next generation of the board's seconds counter and display path. It replaces the fixed 8-bit binary counter, separate 1 s timer and `%10`/`/10` split with one sequential block. It sits between the board clock and the `seg0..segN` outputs of `top`, and adds direction control, synchronous load/clear and a wrap flag.

## Interface
- `DIGITS`, default 2: number of BCD digits (1..8).
- `TICK_DIV`, default 50_000_000: enabled clock cycles per count step (≥1).
- `SEG_ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0; 0 means a lit segment is driven 1.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `en` in 1: prescaler run enable.
- `up` in 1: 1 = count up, 0 = count down.
- `clr` in 1: synchronous clear.
- `load` in 1: synchronous load.
- `load_val` in 4*DIGITS: BCD value to load; digit 0 = bits [3:0].
- `count_bcd` out 4*DIGITS: registered BCD count.
- `tick_o` out 1: one-cycle pulse marking a count step.
- `wrap_o` out 1: one-cycle pulse marking a wrap step.
- `seg` out 8*DIGITS: segment bytes; digit i = bits [8i+7:8i]; bit order {dp,g,f,e,d,c,b,a}.

## Operation
- **Reset values** (`resetn`=0, asynchronous):
  - prescaler = 0, `count_bcd` = 0, `tick_o` = 0, `wrap_o` = 0.
  - `seg` = all segments off: 0xFF per digit if `SEG_ACTIVE_LOW`=1, else 0x00.
- **Priority per edge:** `clr` > `load` > step > hold.
- **clr:**
  - `count_bcd` ← 0 and prescaler ← 0.
  - `tick_o` and `wrap_o` are 0 next cycle.
- **load:**
  - `count_bcd` ← `load_val` and prescaler ← 0; no tick.
  - Any loaded digit > 9 saturates to 9, per digit.
- **Prescaler:**
  - With `en`=1 it counts 0..TICK_DIV-1 and wraps to 0.
  - With `en`=0 it holds its value; no step and no tick.
- **Step:**
  - Occurs on the edge where `en`=1 and prescaler = TICK_DIV-1, with neither `clr` nor `load` asserted.
  - Up: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - Down: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - Up from all-9s gives all-0s; down from all-0s gives all-9s. Both are wraps and set `wrap_o` for the step.
  - `up` is sampled on the step edge only; changing it between steps has no other effect.
- **Segment encoder:**
  - Active-high patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - dp is always off.
  - The pattern is bitwise inverted when `SEG_ACTIVE_LOW`=1.
  - Digit values > 9 cannot occur; the encoder default is all-off.

## Timing
- A step edge updates `count_bcd`. `tick_o`=1 and, on wrap, `wrap_o`=1 during the cycle after that edge, coincident with the new count.
- `seg` is registered from `count_bcd` and lags it by exactly 1 cycle. After reset release, `seg` shows "0…0" on the first edge.
- Step period is TICK_DIV cycles of `en`=1; disabled cycles stretch the period without losing prescaler progress.
- `TICK_DIV`=1: every enabled, non-clr, non-load cycle is a step; `tick_o` stays high continuously while stepping.
- `clr` or `load` on a would-be step edge: the step is discarded and the prescaler restarts at 0. The next step comes TICK_DIV enabled cycles later.
- `resetn` asserted mid-period clears all state immediately, without waiting for a clock. The first step after release comes TICK_DIV enabled cycles later.
- Carry/borrow ripples across all digits within one cycle; there is no multi-cycle propagation.

## Test plan
- **Reset and free run.** DIGITS=2, TICK_DIV=4, reset, then `en`=1, `up`=1 for 40 cycles.
  - Required: `count_bcd` 0x00→0x01 on the 4th edge, then +1 every 4 cycles up to 0x10.
  - Required: `tick_o` high 1 cycle per step; `seg` of digit 0 = 0xC0 then 0xF9, lagging 1 cycle.
- **Up wrap.** Load 0x99, then `up`=1, `en`=1.
  - Required: after 4 cycles `count_bcd`=0x00 with `tick_o`=1 and `wrap_o`=1 in the same cycle.
- **Down wrap and borrow.**
  - Load 0x10, `up`=0, one step: required `count_bcd`=0x09 with `wrap_o`=0.
  - Load 0x00, `up`=0, one step: required `count_bcd`=0x99 with `wrap_o`=1.
- **Priority and saturation.**
  - Assert `clr` and `load` together with `load_val`=0x55: required `count_bcd`=0x00.
  - Load 0xAF: required `count_bcd`=0x99.
  - Assert `load` on the step edge: required no `tick_o`, and the next step comes 4 cycles later.
- **Enable gating.** Toggle `en` 1/0 each cycle with TICK_DIV=4: required one step per 8 cycles, with no lost or extra steps.
- **Async reset mid-operation.** Assert `resetn`=0 between edges at count 0x37:
  - Required: outputs go to reset values before the next edge.
  - Required: `seg`=0xFF, 0xFF until the first edge after release.
